// File: rtl/wish_slave_mem.sv
// ----------------------------------------------------------------------------
// wish_slave_mem
//   Wishbone classic-cycle slave in front of a word-addressed synchronous RAM.
//   A request (cyc_i & stb_i) is captured in IDLE, held for WAIT_STATES idle
//   cycles, then terminated with a single-cycle ack_o. Addresses whose bits
//   above the RAM index are non-zero are flagged out of range: the access is
//   still acknowledged, but writes are dropped, read data is 0 and tagn_o = 0.
//
// Handshake: a transfer is requested while cyc_i & stb_i are both high. The
//   master must hold them until ack_o; dropping either before the ack aborts
//   the cycle (no ack, no write). ack_o is high for exactly one cycle, and
//   dat_o / tagn_o are only meaningful in that cycle (0 / 1 otherwise).
//
// Ports
//   clk_i     in   1       clock, rising edge
//   rst_i     in   1       asynchronous active-low reset
//   adr_i     in   ADDR_W  word address
//   dat_i     in   DATA_W  write data
//   we_i      in   1       1 = write, 0 = read
//   stb_i     in   1       transfer strobe
//   cyc_i     in   1       bus cycle in progress
//   tagn_i    in   1       master tag (not used by this slave)
//   dat_o     out  DATA_W  read data, valid while ack_o = 1
//   ack_o     out  1       cycle termination, one clock wide
//   tagn_o    out  1       0 during ack_o for an out-of-range access
//   dbg_state out  2       current FSM state (0 IDLE, 1 WAIT, 2 ACK)
// ----------------------------------------------------------------------------
module wish_slave_mem #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 32,
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              we_i,
    input  logic              stb_i,
    input  logic              cyc_i,
    input  logic              tagn_i,
    output logic [DATA_W-1:0] dat_o,
    output logic              ack_o,
    output logic              tagn_o,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Request captured in IDLE; used for the rest of the cycle.
    logic [MEM_AW-1:0]  idx_q;
    logic [DATA_W-1:0]  wdat_q;
    logic               we_q;
    logic               oor_q;

    logic               req;
    logic               in_oor;
    logic               capture;
    logic               go_ack;
    logic               mem_wr;

    // Access actually being terminated this cycle. With zero wait states the
    // ack is decided straight from IDLE, so the live bus is used instead of
    // the (not yet loaded) captured copy.
    logic [MEM_AW-1:0]  acc_idx;
    logic [DATA_W-1:0]  acc_dat;
    logic               acc_we;
    logic               acc_oor;

    logic [DATA_W-1:0]  mem [2**MEM_AW];

    logic               unused_tagn;
    assign unused_tagn = tagn_i;

    assign req       = cyc_i & stb_i;
    assign in_oor    = (adr_i[ADDR_W-1:MEM_AW] != '0);
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        go_ack  = 1'b0;
        acc_idx = idx_q;
        acc_dat = wdat_q;
        acc_we  = we_q;
        acc_oor = oor_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        go_ack  = 1'b1;
                        state_d = S_ACK;
                        acc_idx = adr_i[MEM_AW-1:0];
                        acc_dat = dat_i;
                        acc_we  = we_i;
                        acc_oor = in_oor;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    // Master gave up: leave without ack and without writing.
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    go_ack  = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_wr = go_ack & acc_we & ~acc_oor;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            ack_o   <= 1'b0;
            dat_o   <= '0;
            tagn_o  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q  <= adr_i[MEM_AW-1:0];
                wdat_q <= dat_i;
                we_q   <= we_i;
                oor_q  <= in_oor;
            end
            // Outputs are loaded on the edge entering ACK and cleared on the
            // edge leaving it, so they are one clock wide and fully registered.
            ack_o  <= go_ack;
            tagn_o <= ~(go_ack & acc_oor);
            dat_o  <= (go_ack & ~acc_we & ~acc_oor) ? mem[acc_idx] : '0;
        end
    end

    // RAM has no reset; contents survive rst_i. The rst_i term keeps a
    // zero-wait-state request seen during reset from writing.
    always_ff @(posedge clk_i) begin
        if (mem_wr && rst_i) begin
            mem[acc_idx] <= acc_dat;
        end
    end

endmodule

// File: tb/tb_wish_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_wish_slave_mem
//   Directed bench for wish_slave_mem. Two instances share one master bus:
//   u_dut2 (WAIT_STATES = 2) and u_dut0 (WAIT_STATES = 0). use0 selects which
//   instance's outputs the driver tasks watch. Inputs change 1 ns after a
//   rising edge; outputs are sampled on falling edges.
//   Latency is counted in falling edges after the request is driven: one to
//   reach the sampling edge, then WAIT_STATES + 1 edges to the ack, so the ack
//   is seen at count WAIT_STATES + 2.
// ----------------------------------------------------------------------------
module tb_wish_slave_mem;

    logic        clk_i;
    logic        rst_i;
    logic [25:0] adr_i;
    logic [31:0] dat_i;
    logic        we_i;
    logic        stb_i;
    logic        cyc_i;
    logic        tagn_i;

    logic [31:0] dat_o2, dat_o0;
    logic        ack_o2, ack_o0;
    logic        tagn_o2, tagn_o0;
    logic [1:0]  dbg2, dbg0;

    logic        use0;
    logic [31:0] dat_m;
    logic        ack_m;
    logic        tagn_m;

    int n_assert;
    int n_fail;
    int cyc_cnt;

    assign dat_m  = use0 ? dat_o0  : dat_o2;
    assign ack_m  = use0 ? ack_o0  : ack_o2;
    assign tagn_m = use0 ? tagn_o0 : tagn_o2;

    wish_slave_mem #(.WAIT_STATES(2)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i),
        .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .tagn_i(tagn_i),
        .dat_o(dat_o2), .ack_o(ack_o2), .tagn_o(tagn_o2), .dbg_state(dbg2)
    );

    wish_slave_mem #(.WAIT_STATES(0)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i),
        .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .tagn_i(tagn_i),
        .dat_o(dat_o0), .ack_o(ack_o0), .tagn_o(tagn_o0), .dbg_state(dbg0)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!ack_m && n < 20);
    endtask

    task automatic xfer(input logic we, input logic [25:0] adr, input logic [31:0] dat,
                        input int exp_lat, input logic [31:0] exp_rd,
                        input logic exp_tagn, input string tag);
        int n;
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat;
        wait_ack(n);
        check({tag, "_ack"},  32'(ack_m),  32'd1);
        check({tag, "_lat"},  32'(n),      32'(exp_lat));
        check({tag, "_tagn"}, 32'(tagn_m), 32'(exp_tagn));
        if (!we) check({tag, "_dat"}, dat_m, exp_rd);
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_ack_low"},  32'(ack_m),  32'd0);
        check({tag, "_dat_low"},  dat_m,       32'd0);
        check({tag, "_tagn_hi"},  32'(tagn_m), 32'd1);
    endtask

    // Four writes to 0x3FC..0x3FF then four reads, strobe held throughout;
    // the next request is presented right after each ack.
    task automatic bb(input int ws, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] d3, input string tag);
        logic [31:0] wd [4];
        int t_prev;
        int n;
        wd[0] = d0; wd[1] = d1; wd[2] = d2; wd[3] = d3;
        t_prev = 0;
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1;
        we_i = 1'b1; adr_i = 26'h3FC; dat_i = wd[0];
        for (int k = 0; k < 8; k++) begin
            wait_ack(n);
            check($sformatf("%s_ack%0d", tag, k), 32'(ack_m), 32'd1);
            if (k > 0)
                check($sformatf("%s_gap%0d", tag, k), 32'(cyc_cnt - t_prev), 32'(ws + 2));
            if (k >= 4)
                check($sformatf("%s_rd%0d", tag, k - 4), dat_m, wd[k-4]);
            check($sformatf("%s_tagn%0d", tag, k), 32'(tagn_m), 32'd1);
            t_prev = cyc_cnt;
            @(posedge clk_i); #1;
            if (k < 7) begin
                we_i  = (k + 1 < 4);
                adr_i = 26'h3FC + 26'((k + 1) % 4);
                dat_i = wd[(k + 1) % 4];
            end else begin
                cyc_i = 1'b0; stb_i = 1'b0;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        logic saw_ack;
        n_assert = 0; n_fail = 0;
        rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        adr_i = '0; dat_i = '0; tagn_i = 1'b1; use0 = 1'b0;

        // Reset state
        #2 rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ack",   32'(ack_o2),  32'd0);
        check("rst_tagn",  32'(tagn_o2), 32'd1);
        check("rst_dat",   dat_o2,       32'd0);
        check("rst_state", 32'(dbg2),    32'd0);
        check("rst_ack0",  32'(ack_o0),  32'd0);
        @(posedge clk_i); #1 rst_i = 1'b1;

        // Write then read back, WAIT_STATES = 2
        xfer(1'b1, 26'h005, 32'hDEADBEEF, 4, 32'h0, 1'b1, "wr005");
        xfer(1'b0, 26'h005, 32'h0, 4, 32'hDEADBEEF, 1'b1, "rd005");

        // Reset mid-WAIT: pending write lost, outputs idle without a clock edge
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 26'h005; dat_i = 32'h0BADCAFE;
        @(posedge clk_i); #2;
        check("midwait_state", 32'(dbg2), 32'd1);
        rst_i = 1'b0;
        #1;
        check("midrst_ack",   32'(ack_o2),  32'd0);
        check("midrst_tagn",  32'(tagn_o2), 32'd1);
        check("midrst_dat",   dat_o2,       32'd0);
        check("midrst_state", 32'(dbg2),    32'd0);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge clk_i); #1 rst_i = 1'b1;
        xfer(1'b0, 26'h005, 32'h0, 4, 32'hDEADBEEF, 1'b1, "rd005_after_rst");

        // Reset during the ack cycle: ack_o and dat_o drop immediately
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 26'h005;
        wait_ack(n);
        check("ackrst_ack_pre", 32'(ack_o2), 32'd1);
        check("ackrst_dat_pre", dat_o2,      32'hDEADBEEF);
        #1 rst_i = 1'b0;
        #1;
        check("ackrst_ack",  32'(ack_o2),  32'd0);
        check("ackrst_dat",  dat_o2,       32'd0);
        check("ackrst_tagn", 32'(tagn_o2), 32'd1);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge clk_i); #1 rst_i = 1'b1;

        // Out of range: 0x400 aliases index 0 but must not touch it
        xfer(1'b1, 26'h000, 32'hCAFEF00D, 4, 32'h0, 1'b1, "wr000");
        xfer(1'b1, 26'h400, 32'h12345678, 4, 32'h0, 1'b0, "wr400_oor");
        xfer(1'b0, 26'h000, 32'h0, 4, 32'hCAFEF00D, 1'b1, "rd000");
        xfer(1'b0, 26'h400, 32'h0, 4, 32'h00000000, 1'b0, "rd400_oor");

        // Abort: cyc_i dropped one cycle after the request was sampled
        xfer(1'b1, 26'h010, 32'h11111111, 4, 32'h0, 1'b1, "wr010");
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 26'h010; dat_i = 32'hA5A5A5A5;
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0;
        saw_ack = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            saw_ack = saw_ack | ack_o2;
        end
        check("abort_no_ack", 32'(saw_ack), 32'd0);
        check("abort_state",  32'(dbg2),    32'd0);
        xfer(1'b0, 26'h010, 32'h0, 4, 32'h11111111, 1'b1, "rd010_after_abort");

        // Back-to-back with strobe held, WAIT_STATES = 2
        bb(2, 32'h0BADF00D, 32'h1234ABCD, 32'hFEDC0123, 32'h5555AAAA, "bb2");

        // Zero-wait-state instance
        use0 = 1'b1;
        xfer(1'b1, 26'h020, 32'h76543210, 2, 32'h0, 1'b1, "ws0_wr020");
        xfer(1'b0, 26'h020, 32'h0, 2, 32'h76543210, 1'b1, "ws0_rd020");
        xfer(1'b0, 26'h7FF, 32'h0, 2, 32'h00000000, 1'b0, "ws0_rd_oor");
        bb(0, 32'h01020304, 32'hA0B0C0D0, 32'h89ABCDEF, 32'h00FF00FF, "bb0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
